// File: rtl/tag_free_list.sv
// tag_free_list: pool of free rename tags (1 .. 2^tag_w-1; tag 0 is reserved).
// Issues the head tag to the tag issuer and reclaims retired tags.
// After reset or Flush, an init sequence loads tags 1..N-1 in order.
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   Available      head tag valid (issuer handshake Valid)
//   Enable         issuer consumes the head tag this cycle
//   Tag            head tag; meaningful only while Available=1
//   RetValid       a retired tag is being returned
//   RetTag         returned tag value
//   RetReady       return accepted this cycle when RetValid=1
//   Flush          synchronous discard and re-initialisation
//   Count          number of free tags held
//   Error          sticky flag for illegal returns (tag 0, or return to a full pool)
module tag_free_list #(
  parameter int unsigned tag_w = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic             Available,
  input  logic             Enable,
  output logic [tag_w-1:0] Tag,
  input  logic             RetValid,
  input  logic [tag_w-1:0] RetTag,
  output logic             RetReady,
  input  logic             Flush,
  output logic [tag_w-1:0] Count,
  output logic             Error
);

  localparam int unsigned N = 1 << tag_w;
  // All-ones is both the last init tag and the full-pool Count (N-1).
  localparam logic [tag_w-1:0] LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [tag_w-1:0] k_q, k_d;
  logic [tag_w-1:0] head_q, head_d;
  logic [tag_w-1:0] tail_q, tail_d;
  logic [tag_w-1:0] count_q, count_d;
  logic             error_q, error_d;

  logic [tag_w-1:0] mem_q [N];
  logic             wr_en;
  logic [tag_w-1:0] wr_data;

  logic pop, ret, illegal, push;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (Flush)                                state_d = S_INIT;
    else if (state_q == S_INIT && k_q == LAST) state_d = S_RUN;
  end

  // Outputs: all derived from registered state
  always_comb begin
    Available = (state_q == S_RUN) && (count_q != '0);
    RetReady  = (state_q == S_RUN);
    Tag       = mem_q[head_q];
    Count     = count_q;
    Error     = error_q;
  end

  // Datapath next-state
  always_comb begin
    pop     = Enable & Available;
    ret     = RetValid & RetReady;
    // Full is judged before this cycle's pop, so a return to a full pool
    // is dropped even if a tag leaves in the same cycle.
    illegal = ret & ((RetTag == '0) | (count_q == LAST));
    push    = ret & ~illegal;

    k_d     = k_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    error_d = error_q;
    wr_en   = 1'b0;
    wr_data = RetTag;

    if (Flush) begin
      k_d     = tag_w'(1);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      error_d = 1'b0;
    end else if (state_q == S_INIT) begin
      wr_en   = 1'b1;
      wr_data = k_q;
      tail_d  = tail_q + tag_w'(1);
      count_d = count_q + tag_w'(1);
      k_d     = k_q + tag_w'(1);
    end else begin
      if (pop) head_d = head_q + tag_w'(1);
      if (push) begin
        wr_en  = 1'b1;
        tail_d = tail_q + tag_w'(1);
      end
      if (illegal) error_d = 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + tag_w'(1);
        2'b01:   count_d = count_q - tag_w'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q     <= tag_w'(1);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      k_q     <= k_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Tag storage: no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= wr_data;
  end

endmodule

// File: tb/tb_tag_free_list.sv
module tb_tag_free_list;

  localparam int TW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Enable = 1'b0;
  logic          RetValid = 1'b0;
  logic [TW-1:0] RetTag = '0;
  logic          Flush = 1'b0;
  logic          Available, RetReady, Error;
  logic [TW-1:0] Tag, Count;

  int tests = 0;
  int fails = 0;

  // Behavioural model: the pool is a plain queue of free tags.
  int mq[$];
  bit m_init = 1'b1;
  int m_k    = 1;
  bit m_err  = 1'b0;
  bit m_pop, m_push, exp_avail;

  tag_free_list #(.tag_w(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .Available (Available),
    .Enable    (Enable),
    .Tag       (Tag),
    .RetValid  (RetValid),
    .RetTag    (RetTag),
    .RetReady  (RetReady),
    .Flush     (Flush),
    .Count     (Count),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst || Flush) begin
      mq.delete();
      m_init = 1'b1;
      m_k    = 1;
      m_err  = 1'b0;
    end else if (m_init) begin
      mq.push_back(m_k);
      if (m_k == N-1) m_init = 1'b0;
      m_k++;
    end else begin
      m_pop  = Enable && (mq.size() != 0);
      m_push = 1'b0;
      if (RetValid) begin
        if (RetTag == 0 || mq.size() == N-1) m_err = 1'b1;
        else m_push = 1'b1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(int'(RetTag));
    end
  end

  // Compare process: every falling edge
  initial forever begin
    @(negedge clk);
    exp_avail = !m_init && (mq.size() != 0);
    check("cmp Available", 32'(Available), 32'(exp_avail));
    check("cmp RetReady", 32'(RetReady), 32'(!m_init));
    check("cmp Count", 32'(Count), 32'(mq.size()));
    check("cmp Error", 32'(Error), 32'(m_err));
    if (exp_avail) check("cmp Tag", 32'(Tag), 32'(mq[0]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string nm);
    repeat (62) tick();
    check({nm, " avail still low"}, 32'(Available), 0);
    tick();
    check({nm, " avail"}, 32'(Available), 1);
    check({nm, " tag"}, 32'(Tag), 1);
    check({nm, " count"}, 32'(Count), 63);
    check({nm, " retready"}, 32'(RetReady), 1);
  endtask

  int sim_exp[6];

  initial begin
    sim_exp[0] = 17; sim_exp[1] = 20; sim_exp[2] = 21;
    sim_exp[3] = 22; sim_exp[4] = 23; sim_exp[5] = 30;

    // Reset
    #2 rst = 1'b0;
    #1;
    check("reset avail", 32'(Available), 0);
    check("reset retready", 32'(RetReady), 0);
    check("reset count", 32'(Count), 0);
    check("reset error", 32'(Error), 0);
    tick();
    tick();
    rst = 1'b1;
    wait_init("init");

    // Drain
    Enable = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      check("drain tag", 32'(Tag), 32'(i));
      tick();
    end
    check("drained avail", 32'(Available), 0);
    check("drained count", 32'(Count), 0);
    repeat (3) tick();
    check("extra enable count", 32'(Count), 0);

    // Return at empty, with Enable still high
    RetValid = 1'b1;
    RetTag   = 6'd17;
    check("empty ret avail", 32'(Available), 0);
    check("empty ret ready", 32'(RetReady), 1);
    tick();
    RetValid = 1'b0;
    Enable   = 1'b0;
    check("ret17 avail", 32'(Available), 1);
    check("ret17 tag", 32'(Tag), 17);
    check("ret17 count", 32'(Count), 1);

    // Build Count=5 with head at entry 63, then simultaneous pop/push across wrap
    for (int t = 20; t <= 23; t++) begin
      RetValid = 1'b1;
      RetTag   = TW'(t);
      tick();
    end
    RetValid = 1'b0;
    check("pre-sim count", 32'(Count), 5);
    check("pre-sim tag", 32'(Tag), 17);
    for (int i = 0; i < 6; i++) begin
      Enable   = 1'b1;
      RetValid = 1'b1;
      RetTag   = TW'(30 + i);
      check("sim tag", 32'(Tag), 32'(sim_exp[i]));
      tick();
      check("sim count", 32'(Count), 5);
    end
    Enable   = 1'b0;
    RetValid = 1'b0;

    // Illegal return of tag 0
    RetValid = 1'b1;
    RetTag   = '0;
    tick();
    RetValid = 1'b0;
    check("ret0 error", 32'(Error), 1);
    check("ret0 count", 32'(Count), 5);

    // Fill to 63, then return to a full pool
    for (int i = 0; i < 58; i++) begin
      RetValid = 1'b1;
      RetTag   = TW'((i % 62) + 1);
      tick();
    end
    check("filled count", 32'(Count), 63);
    RetTag = 6'd4;
    tick();
    check("full ret count", 32'(Count), 63);
    check("full ret error", 32'(Error), 1);
    Enable = 1'b1;
    RetTag = 6'd9;
    tick();
    check("full pop+ret count", 32'(Count), 62);
    check("full pop+ret tag", 32'(Tag), 32);

    // Flush with pops/returns discarded
    Flush = 1'b1;
    tick();
    Flush    = 1'b0;
    Enable   = 1'b0;
    RetValid = 1'b0;
    check("flush error", 32'(Error), 0);
    check("flush count", 32'(Count), 0);
    check("flush avail", 32'(Available), 0);
    check("flush retready", 32'(RetReady), 0);
    wait_init("reinit");

    // Async reset mid-drain
    Enable = 1'b1;
    repeat (33) tick();
    check("middrain count", 32'(Count), 30);
    check("middrain tag", 32'(Tag), 34);
    #2 rst = 1'b0;
    #1;
    check("async avail", 32'(Available), 0);
    check("async retready", 32'(RetReady), 0);
    check("async count", 32'(Count), 0);
    check("async error", 32'(Error), 0);
    Enable = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_init("postreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
